// File: rtl/fan_ctrl_if.sv
// fan_ctrl_if: bundle of the handshake and bus signals around fan_ctrl.
//   cfg_*  : configuration stream into the scheduler (valid/ready)
//   in_*   : data beat stream into the scheduler (valid/ready)
//   tree_* : registered issue-stage drive to fan_tree, plus its results
//   out_*  : registered result stream (valid/ready)
//   busy   : scheduler has queued or in-flight work
// Modports: slave = fan_ctrl side, master = environment side.
interface fan_ctrl_if #(
    parameter int N        = 8,
    parameter int DW_DATA  = 8,
    parameter int N_ADDERS = N - 1
);
    logic                            cfg_valid;
    logic                            cfg_ready;
    logic [N_ADDERS-1:0]             cfg_add_en;
    logic [N_ADDERS-1:0]             cfg_bypass_en;
    logic [6*N_ADDERS-1:0]           cfg_sel;
    logic [7:0]                      cfg_repeat;

    logic                            in_valid;
    logic                            in_ready;
    logic [DW_DATA*N-1:0]            in_data;
    logic [2*N-1:0]                  in_tag;

    logic [N_ADDERS-1:0]             tree_add_en;
    logic [N_ADDERS-1:0]             tree_bypass_en;
    logic [6*N_ADDERS-1:0]           tree_sel;
    logic [DW_DATA*N-1:0]            tree_in;
    logic [2*N-1:0]                  tree_edge_tag_in;
    logic [2*N_ADDERS-1:0]           tree_out_valid;
    logic [DW_DATA*2*N_ADDERS-1:0]   tree_out;

    logic                            out_valid;
    logic                            out_ready;
    logic [DW_DATA*2*N_ADDERS-1:0]   out_data;
    logic [2*N_ADDERS-1:0]           out_lane_valid;
    logic                            busy;

    modport slave (
        input  cfg_valid, cfg_add_en, cfg_bypass_en, cfg_sel, cfg_repeat,
        input  in_valid, in_data, in_tag,
        input  tree_out_valid, tree_out,
        input  out_ready,
        output cfg_ready, in_ready,
        output tree_add_en, tree_bypass_en, tree_sel, tree_in, tree_edge_tag_in,
        output out_valid, out_data, out_lane_valid, busy
    );

    modport master (
        output cfg_valid, cfg_add_en, cfg_bypass_en, cfg_sel, cfg_repeat,
        output in_valid, in_data, in_tag,
        output tree_out_valid, tree_out,
        output out_ready,
        input  cfg_ready, in_ready,
        input  tree_add_en, tree_bypass_en, tree_sel, tree_in, tree_edge_tag_in,
        input  out_valid, out_data, out_lane_valid, busy
    );
endinterface

// File: rtl/fan_ctrl.sv
// fan_ctrl: configuration scheduler and two-stage pipeline wrapper for fan_tree.
// Configurations (each with a repeat count) queue in a small FIFO; the head is
// made active and bound to the next max(repeat,1) data beats. Each accepted beat
// is latched with a copy of its configuration in the issue stage (driving the
// tree), and the tree result is captured in the output stage.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   flush : synchronous clear of all queued and in-flight work
//   bus   : fan_ctrl_if.slave (cfg_*, in_*, tree_*, out_*, busy)
//
// state  | meaning
// NOCFG  | no configuration active, data not accepted
// ACTIVE | configuration loaded, r_beats_left beats remain
module fan_ctrl #(
    parameter int N         = 8,
    parameter int DW_DATA   = 8,
    parameter int N_ADDERS  = N - 1,
    parameter int CFG_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    fan_ctrl_if.slave bus
);
    localparam int PW   = $clog2(CFG_DEPTH);
    localparam int CNTW = PW + 1;

    typedef struct packed {
        logic [N_ADDERS-1:0]   add_en;
        logic [N_ADDERS-1:0]   bypass_en;
        logic [6*N_ADDERS-1:0] sel;
        logic [7:0]            rpt;
    } cfg_t;

    typedef enum logic {NOCFG = 1'b0, ACTIVE = 1'b1} state_t;

    state_t                        r_state, w_state_nxt;
    cfg_t                          r_fifo [CFG_DEPTH];
    logic [PW-1:0]                 r_wr_ptr, r_rd_ptr;
    logic [CNTW-1:0]               r_count;
    logic [N_ADDERS-1:0]           r_act_add, r_act_byp;
    logic [6*N_ADDERS-1:0]         r_act_sel;
    logic [7:0]                    r_beats_left;
    logic                          r_iss_valid;
    logic [N_ADDERS-1:0]           r_iss_add, r_iss_byp;
    logic [6*N_ADDERS-1:0]         r_iss_sel;
    logic [DW_DATA*N-1:0]          r_iss_data;
    logic [2*N-1:0]                r_iss_tag;
    logic                          r_out_valid;
    logic [DW_DATA*2*N_ADDERS-1:0] r_out_data;
    logic [2*N_ADDERS-1:0]         r_out_lane_valid;

    cfg_t w_cfg_in, w_head;
    logic w_cfg_ready, w_fifo_ne, w_push, w_pop;
    logic w_out_adv, w_iss_adv, w_in_ready, w_in_acc;

    assign w_cfg_in    = '{add_en: bus.cfg_add_en, bypass_en: bus.cfg_bypass_en,
                           sel: bus.cfg_sel, rpt: bus.cfg_repeat};
    assign w_head      = r_fifo[r_rd_ptr];
    // Ready depends on occupancy only: a same-cycle pop never opens a full FIFO.
    assign w_cfg_ready = (r_count != CNTW'(CFG_DEPTH));
    assign w_fifo_ne   = (r_count != '0);
    assign w_push      = bus.cfg_valid && w_cfg_ready && !flush;

    assign w_out_adv   = !r_out_valid || bus.out_ready;
    assign w_iss_adv   = r_iss_valid && w_out_adv;
    assign w_in_ready  = (r_state == ACTIVE) && (!r_iss_valid || w_iss_adv);
    assign w_in_acc    = bus.in_valid && w_in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= NOCFG;
        else        r_state <= w_state_nxt;
    end

    // Pop doubles as "load active register"; retiring on the last beat pops
    // the next head in the same edge so there is no bubble between configs.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            NOCFG: begin
                if (w_fifo_ne) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (w_in_acc && (r_beats_left == 8'd1)) begin
                    if (w_fifo_ne) w_pop       = 1'b1;
                    else           w_state_nxt = NOCFG;
                end
            end
            default: w_state_nxt = NOCFG;
        endcase
        if (flush) begin
            w_state_nxt = NOCFG;
            w_pop       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CFG_DEPTH; i++) r_fifo[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_cfg_in;
                r_wr_ptr         <= r_wr_ptr + PW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CNTW'(w_push) - CNTW'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_add    <= '0;
            r_act_byp    <= '0;
            r_act_sel    <= '0;
            r_beats_left <= '0;
        end else if (!flush) begin
            if (w_pop) begin
                r_act_add    <= w_head.add_en;
                r_act_byp    <= w_head.bypass_en;
                r_act_sel    <= w_head.sel;
                r_beats_left <= (w_head.rpt == 8'd0) ? 8'd1 : w_head.rpt;
            end else if (w_in_acc) begin
                r_beats_left <= r_beats_left - 8'd1;
            end
        end
    end

    // Issue stage carries its own config copy so a retiring config never
    // changes what the tree sees for a beat already issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iss_valid <= 1'b0;
            r_iss_add   <= '0;
            r_iss_byp   <= '0;
            r_iss_sel   <= '0;
            r_iss_data  <= '0;
            r_iss_tag   <= '0;
        end else if (flush) begin
            r_iss_valid <= 1'b0;
        end else if (w_in_acc) begin
            r_iss_valid <= 1'b1;
            r_iss_add   <= r_act_add;
            r_iss_byp   <= r_act_byp;
            r_iss_sel   <= r_act_sel;
            r_iss_data  <= bus.in_data;
            r_iss_tag   <= bus.in_tag;
        end else if (w_iss_adv) begin
            r_iss_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid      <= 1'b0;
            r_out_data       <= '0;
            r_out_lane_valid <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_iss_adv) begin
            r_out_valid      <= 1'b1;
            r_out_data       <= bus.tree_out;
            r_out_lane_valid <= bus.tree_out_valid;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.cfg_ready        = w_cfg_ready;
    assign bus.in_ready         = w_in_ready;
    assign bus.tree_add_en      = r_iss_add;
    assign bus.tree_bypass_en   = r_iss_byp;
    assign bus.tree_sel         = r_iss_sel;
    assign bus.tree_in          = r_iss_data;
    assign bus.tree_edge_tag_in = r_iss_tag;
    assign bus.out_valid        = r_out_valid;
    assign bus.out_data         = r_out_data;
    assign bus.out_lane_valid   = r_out_lane_valid;
    assign bus.busy             = w_fifo_ne || (r_state == ACTIVE) || r_iss_valid || r_out_valid;
endmodule

// File: tb/tb_fan_ctrl.sv
module tb_fan_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    fan_ctrl_if #(.N(8), .DW_DATA(8), .N_ADDERS(7)) bus ();

    fan_ctrl #(.N(8), .DW_DATA(8), .N_ADDERS(7), .CFG_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Stand-in tree: results echo the lane data, result valids echo the config.
    assign bus.tree_out       = {bus.tree_in[47:0], bus.tree_in};
    assign bus.tree_out_valid = {bus.tree_add_en, bus.tree_bypass_en};

    typedef struct {
        logic       cfg_v;
        logic [6:0] add;
        logic [7:0] rep;
        logic       in_v;
        logic [7:0] d;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_d;
        logic [6:0] e_add;
        logic       e_busy;
        logic       tchk;
        logic [6:0] e_tree;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic v, input logic [6:0] add, input logic [7:0] rep);
        bus.cfg_valid     = v;
        bus.cfg_add_en    = add;
        bus.cfg_bypass_en = ~add;
        bus.cfg_sel       = {6{add}};
        bus.cfg_repeat    = rep;
    endtask

    task automatic set_in(input logic v, input logic [7:0] d);
        bus.in_valid = v;
        bus.in_data  = {8{d}};
        bus.in_tag   = {2{d}};
    endtask

    function automatic logic [111:0] exp_out(input logic [7:0] d);
        return {14{d}};
    endfunction

    function automatic logic [13:0] exp_lane(input logic [6:0] a);
        return {a, ~a};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] next_d;
        logic [7:0] d_exp;
        int         n_out;

        //         cfg  add    rep  inv d      ordy ir ov e_d    e_add  busy tchk e_tree
        vt[0]  = '{1, 7'h15, 8'd3, 0, 8'h00, 1,   0, 0, 8'h00, 7'h00, 0,   0, 7'h00};
        vt[1]  = '{0, 7'h00, 8'd0, 1, 8'h10, 1,   0, 0, 8'h00, 7'h00, 1,   0, 7'h00};
        vt[2]  = '{0, 7'h00, 8'd0, 1, 8'h10, 1,   1, 0, 8'h00, 7'h00, 1,   0, 7'h00};
        vt[3]  = '{0, 7'h00, 8'd0, 1, 8'h11, 1,   1, 0, 8'h00, 7'h00, 1,   1, 7'h15};
        vt[4]  = '{0, 7'h00, 8'd0, 1, 8'h12, 1,   1, 1, 8'h10, 7'h15, 1,   1, 7'h15};
        vt[5]  = '{0, 7'h00, 8'd0, 0, 8'h00, 1,   0, 1, 8'h11, 7'h15, 1,   1, 7'h15};
        vt[6]  = '{0, 7'h00, 8'd0, 0, 8'h00, 1,   0, 1, 8'h12, 7'h15, 1,   0, 7'h00};
        vt[7]  = '{1, 7'h33, 8'd2, 0, 8'h00, 1,   0, 0, 8'h00, 7'h00, 0,   0, 7'h00};
        vt[8]  = '{1, 7'h4C, 8'd0, 0, 8'h00, 1,   0, 0, 8'h00, 7'h00, 1,   0, 7'h00};
        vt[9]  = '{0, 7'h00, 8'd0, 1, 8'h20, 1,   1, 0, 8'h00, 7'h00, 1,   0, 7'h00};
        vt[10] = '{0, 7'h00, 8'd0, 1, 8'h21, 1,   1, 0, 8'h00, 7'h00, 1,   1, 7'h33};
        vt[11] = '{0, 7'h00, 8'd0, 1, 8'h22, 1,   1, 1, 8'h20, 7'h33, 1,   1, 7'h33};
        vt[12] = '{0, 7'h00, 8'd0, 0, 8'h00, 1,   0, 1, 8'h21, 7'h33, 1,   1, 7'h4C};
        vt[13] = '{0, 7'h00, 8'd0, 0, 8'h00, 1,   0, 1, 8'h22, 7'h4C, 1,   0, 7'h00};
        vt[14] = '{0, 7'h00, 8'd0, 0, 8'h00, 1,   0, 0, 8'h00, 7'h00, 0,   0, 7'h00};

        set_cfg(0, 7'h00, 8'd0);
        set_in(0, 8'h00);
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #23;
        chk("rst cfg_ready", bus.cfg_ready, 1);
        chk("rst in_ready", bus.in_ready, 0);
        chk("rst busy", bus.busy, 0);
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst out_data", bus.out_data, 0);
        chk("rst tree_in", bus.tree_in, 0);
        rst_n = 1'b1;
        tick();

        // Single config then back-to-back configs (second with repeat 0).
        for (int i = 0; i < 15; i++) begin
            set_cfg(vt[i].cfg_v, vt[i].add, vt[i].rep);
            set_in(vt[i].in_v, vt[i].d);
            bus.out_ready = vt[i].ordy;
            #1;
            chk($sformatf("v%0d in_ready", i), bus.in_ready, vt[i].e_ir);
            chk($sformatf("v%0d out_valid", i), bus.out_valid, vt[i].e_ov);
            chk($sformatf("v%0d busy", i), bus.busy, vt[i].e_busy);
            if (vt[i].e_ov) begin
                chk($sformatf("v%0d out_data", i), bus.out_data, exp_out(vt[i].e_d));
                chk($sformatf("v%0d out_lane_valid", i), bus.out_lane_valid, exp_lane(vt[i].e_add));
            end
            if (vt[i].tchk) begin
                chk($sformatf("v%0d tree_add_en", i), bus.tree_add_en, vt[i].e_tree);
                chk($sformatf("v%0d tree_sel", i), bus.tree_sel, {6{vt[i].e_tree}});
            end
            tick();
        end
        set_cfg(0, 7'h00, 8'd0);
        set_in(0, 8'h00);

        // FIFO full: five pushes accepted (one active + four queued), sixth refused.
        for (int k = 0; k < 6; k++) begin
            set_cfg(1, 7'(k + 1), 8'((k == 0) ? 0 : 1));
            #1;
            chk($sformatf("full k%0d cfg_ready", k), bus.cfg_ready, (k < 5));
            tick();
        end
        // Drain: one beat per config; a push offered while full must not land.
        for (int k = 0; k < 8; k++) begin
            set_cfg(k == 0, 7'h7F, 8'd1);
            set_in(k < 5, 8'(8'h30 + k));
            bus.out_ready = 1'b1;
            #1;
            chk($sformatf("drain k%0d in_ready", k), bus.in_ready, (k < 5));
            if (k == 0) chk("drain full cfg_ready", bus.cfg_ready, 0);
            if (k == 1) chk("drain after pop cfg_ready", bus.cfg_ready, 1);
            if (k >= 2 && k < 7) begin
                chk($sformatf("drain k%0d out_valid", k), bus.out_valid, 1);
                chk($sformatf("drain k%0d out_data", k), bus.out_data, exp_out(8'(8'h30 + k - 2)));
                chk($sformatf("drain k%0d lane", k), bus.out_lane_valid, exp_lane(7'(k - 1)));
            end
            if (k == 7) begin
                chk("drain end busy", bus.busy, 0);
                chk("drain end out_valid", bus.out_valid, 0);
            end
            tick();
        end
        set_cfg(0, 7'h00, 8'd0);
        set_in(0, 8'h00);

        // Backpressure: out_ready low for 5 cycles mid-stream.
        set_cfg(1, 7'h11, 8'd6);
        tick();
        set_cfg(0, 7'h00, 8'd0);
        tick();
        next_d = 8'h40;
        n_out  = 0;
        for (int t = 0; t < 20; t++) begin
            bus.out_ready = !(t >= 3 && t < 8);
            set_in(1, next_d);
            #1;
            if (t >= 3 && t < 8) begin
                chk($sformatf("bp t%0d in_ready", t), bus.in_ready, 0);
                chk($sformatf("bp t%0d out_valid", t), bus.out_valid, 1);
                chk($sformatf("bp t%0d out_data stable", t), bus.out_data, exp_out(8'h41));
                chk($sformatf("bp t%0d issue beat", t), bus.tree_in, {8{8'h42}});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("bp unexpected output", bus.out_data, 0);
                    chk("bp unexpected output valid", bus.out_valid, 0);
                end else begin
                    d_exp = q.pop_front();
                    chk($sformatf("bp out #%0d", n_out), bus.out_data, exp_out(d_exp));
                    chk($sformatf("bp lane #%0d", n_out), bus.out_lane_valid, exp_lane(7'h11));
                    n_out++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(next_d);
                next_d = next_d + 8'd1;
            end
            tick();
        end
        set_in(0, 8'h00);
        chk("bp outputs delivered", n_out, 6);
        chk("bp beats accepted", next_d, 8'h46);
        chk("bp busy after drain", bus.busy, 0);

        // Flush with two queued configs and both stages valid.
        bus.out_ready = 1'b0;
        set_cfg(1, 7'h01, 8'd4);
        tick();
        set_cfg(1, 7'h02, 8'd4);
        tick();
        set_cfg(1, 7'h03, 8'd4);
        tick();
        set_cfg(0, 7'h00, 8'd0);
        set_in(1, 8'h50);
        tick();
        set_in(1, 8'h51);
        tick();
        chk("pre-flush out_valid", bus.out_valid, 1);
        chk("pre-flush busy", bus.busy, 1);
        flush = 1'b1;
        set_cfg(1, 7'h04, 8'd4);
        set_in(1, 8'h52);
        bus.out_ready = 1'b1;
        tick();
        flush = 1'b0;
        set_cfg(0, 7'h00, 8'd0);
        set_in(0, 8'h00);
        #1;
        chk("flush out_valid", bus.out_valid, 0);
        chk("flush in_ready", bus.in_ready, 0);
        chk("flush busy", bus.busy, 0);
        chk("flush cfg_ready", bus.cfg_ready, 1);
        tick();
        chk("flush+1 out_valid", bus.out_valid, 0);
        chk("flush+1 busy", bus.busy, 0);

        // Asynchronous reset between edges mid-stream.
        set_cfg(1, 7'h05, 8'd4);
        tick();
        set_cfg(0, 7'h00, 8'd0);
        tick();
        set_in(1, 8'h60);
        tick();
        set_in(1, 8'h61);
        tick();
        chk("pre-reset out_valid", bus.out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst out_valid", bus.out_valid, 0);
        chk("arst busy", bus.busy, 0);
        chk("arst in_ready", bus.in_ready, 0);
        chk("arst cfg_ready", bus.cfg_ready, 1);
        chk("arst tree_in", bus.tree_in, 0);
        chk("arst tree_add_en", bus.tree_add_en, 0);
        chk("arst out_data", bus.out_data, 0);
        set_in(0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("post-reset c%0d out_valid", k), bus.out_valid, 0);
            chk($sformatf("post-reset c%0d busy", k), bus.busy, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
